// File: rtl/piezo_sound_ctrl_if.sv
// Request/status bundle between the game FSM and the piezo sequencer.
// Latency: none (wires only).
// Backpressure: none; requests are level-sampled every cycle, never stalled.
interface piezo_sound_ctrl_if;
  logic       req_tick;
  logic       req_defused;
  logic       req_explode;
  logic       pizo;
  logic       busy;
  logic [1:0] cur_src;

  modport master (
    output req_tick, req_defused, req_explode,
    input  pizo, busy, cur_src
  );

  modport slave (
    input  req_tick, req_defused, req_explode,
    output pizo, busy, cur_src
  );
endinterface

// File: rtl/piezo_sound_ctrl.sv
// Piezo arbiter/sequencer: latches tick/defused/explode requests, grants by
// fixed priority with preemption and plays the granted note pattern as a square wave.
// Latency: request to sound 2 cycles. Backpressure: none; losing requests are discarded.
module piezo_sound_ctrl #(
  parameter int HP0        = 2272,
  parameter int HP1        = 1912,
  parameter int HP2        = 1516,
  parameter int HP3        = 1275,
  parameter int NOTE_LEN   = 250000,
  parameter int TICK_LEN   = 50000,
  parameter int ALARM_REPS = 8
) (
  input  logic               clk,
  input  logic               rst,
  piezo_sound_ctrl_if.slave  bus
);

  localparam int HP_MAX01 = (HP0 > HP1) ? HP0 : HP1;
  localparam int HP_MAX23 = (HP2 > HP3) ? HP2 : HP3;
  localparam int HP_MAX   = (HP_MAX01 > HP_MAX23) ? HP_MAX01 : HP_MAX23;
  localparam int LEN_MAX  = (NOTE_LEN > TICK_LEN) ? NOTE_LEN : TICK_LEN;
  localparam int TW       = $clog2(HP_MAX + 1);
  localparam int DW       = $clog2(LEN_MAX + 1);
  localparam int RW       = $clog2(ALARM_REPS + 1);

  // State encoding doubles as the cur_src code.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TICK   = 2'd1,
    ST_MELODY = 2'd2,
    ST_ALARM  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      note_q, note_d;
  logic [RW-1:0]   rep_q, rep_d;
  logic [DW-1:0]   dur_q, dur_d;
  logic [TW-1:0]   tone_q, tone_d;
  logic            pizo_q, pizo_d;
  logic            busy_q, busy_d;
  logic            pend_t_q, pend_t_d;
  logic            pend_d_q, pend_d_d;
  logic            pend_e_q, pend_e_d;

  logic [TW-1:0]   hp_cur;
  logic            clr_t, clr_d, clr_e;
  logic            grant_e, grant_m, grant_t;
  logic            note_start;

  // Half-period of the note currently sounding.
  always_comb begin
    hp_cur = TW'(HP0);
    case (note_q)
      2'd0:    hp_cur = TW'(HP0);
      2'd1:    hp_cur = TW'(HP1);
      2'd2:    hp_cur = TW'(HP2);
      default: hp_cur = TW'(HP3);
    endcase
  end

  // Next-state: arbitration, note sequencing, tone and duration counting.
  always_comb begin
    state_d    = state_q;
    note_d     = note_q;
    rep_d      = rep_q;
    clr_t      = 1'b0;
    clr_d      = 1'b0;
    clr_e      = 1'b0;
    grant_e    = 1'b0;
    grant_m    = 1'b0;
    grant_t    = 1'b0;
    note_start = 1'b0;

    dur_d = dur_q + DW'(1);
    if (tone_q == hp_cur - TW'(1)) begin
      tone_d = '0;
      pizo_d = ~pizo_q;
    end else begin
      tone_d = tone_q + TW'(1);
      pizo_d = pizo_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_e_q)      grant_e = 1'b1;
        else if (pend_d_q) grant_m = 1'b1;
        else if (pend_t_q) grant_t = 1'b1;
      end
      ST_TICK: begin
        // A tick queued behind this one stays pending until we return to IDLE.
        if (pend_e_q)                          grant_e = 1'b1;
        else if (pend_d_q)                     grant_m = 1'b1;
        else if (dur_q == DW'(TICK_LEN - 1))   state_d = ST_IDLE;
      end
      ST_MELODY: begin
        if (pend_e_q) begin
          grant_e = 1'b1;
        end else begin
          clr_d = 1'b1;
          clr_t = 1'b1;
          if (dur_q == DW'(NOTE_LEN - 1)) begin
            if (note_q == 2'd3) begin
              state_d = ST_IDLE;
            end else begin
              note_d     = note_q + 2'd1;
              note_start = 1'b1;
            end
          end
        end
      end
      ST_ALARM: begin
        // The alarm is uninterruptible; every request is dropped while it plays.
        clr_e = 1'b1;
        clr_d = 1'b1;
        clr_t = 1'b1;
        if (dur_q == DW'(NOTE_LEN - 1)) begin
          if (note_q == 2'd0) begin
            note_d     = 2'd3;
            note_start = 1'b1;
          end else if (rep_q == RW'(ALARM_REPS - 1)) begin
            state_d = ST_IDLE;
          end else begin
            rep_d      = rep_q + RW'(1);
            note_d     = 2'd0;
            note_start = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (grant_e) begin
      state_d    = ST_ALARM;
      note_d     = 2'd0;
      rep_d      = '0;
      note_start = 1'b1;
      clr_e      = 1'b1;
      clr_d      = 1'b1;
      clr_t      = 1'b1;
    end else if (grant_m) begin
      state_d    = ST_MELODY;
      note_d     = 2'd0;
      note_start = 1'b1;
      clr_d      = 1'b1;
      clr_t      = 1'b1;
    end else if (grant_t) begin
      state_d    = ST_TICK;
      note_d     = 2'd3;
      note_start = 1'b1;
      clr_t      = 1'b1;
    end

    // Every note begins from a clean low phase; IDLE holds the pin low.
    if (note_start || (state_d == ST_IDLE)) begin
      dur_d  = '0;
      tone_d = '0;
      pizo_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);

    // A fresh request on the same edge as a clear keeps the flag set.
    pend_t_d = bus.req_tick    | (pend_t_q & ~clr_t);
    pend_d_d = bus.req_defused | (pend_d_q & ~clr_d);
    pend_e_d = bus.req_explode | (pend_e_q & ~clr_e);
  end

  // All sequencer state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      note_q   <= 2'd0;
      rep_q    <= '0;
      dur_q    <= '0;
      tone_q   <= '0;
      pizo_q   <= 1'b0;
      busy_q   <= 1'b0;
      pend_t_q <= 1'b0;
      pend_d_q <= 1'b0;
      pend_e_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      note_q   <= note_d;
      rep_q    <= rep_d;
      dur_q    <= dur_d;
      tone_q   <= tone_d;
      pizo_q   <= pizo_d;
      busy_q   <= busy_d;
      pend_t_q <= pend_t_d;
      pend_d_q <= pend_d_d;
      pend_e_q <= pend_e_d;
    end
  end

  assign bus.pizo    = pizo_q;
  assign bus.busy    = busy_q;
  assign bus.cur_src = state_q;

endmodule

// File: doc/piezo_sound_ctrl.md
# piezo_sound_ctrl

Sequencer and arbiter for the single bomb-panel piezo. It accepts three sound requests (countdown tick, defused melody, explosion alarm), grants the piezo by fixed priority with preemption, and sequences the notes of the granted pattern. It drives the square wave directly from an internal half-period counter, so no per-note clock dividers or output mux are needed. It sits between the game FSM and the piezo pin.

## Interface
- HP0, 2272, half-period in clk cycles of note 0 (lowest)
- HP1, 1912, half-period of note 1
- HP2, 1516, half-period of note 2
- HP3, 1275, half-period of note 3 (highest)
- NOTE_LEN, 250000, clk cycles per melody/alarm note
- TICK_LEN, 50000, clk cycles of the tick beep
- ALARM_REPS, 8, number of (note0, note3) pairs in the alarm; must be ≥ 1
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_tick  in  1  tick request; sampled every cycle, high = request
- req_defused  in  1  defused-melody request
- req_explode  in  1  explosion-alarm request
- pizo  out  1  square-wave drive to the piezo
- busy  out  1  high while any pattern is playing
- cur_src  out  2  active source: 0 none, 1 tick, 2 defused, 3 explode

## Operation
- Reset: state IDLE, pizo=0, busy=0, cur_src=0. All pending flags, note counters, duration counters and the tone counter are cleared.
- Pending flags pend_t, pend_d, pend_e are set by their req_* inputs on the sampling edge. If a set and a clear hit the same edge, the set wins.
- Priority: explode > defused > tick.
- A grant is made from the pending flags, never directly from req_*. The granted flag clears on the grant edge.
- States:
  - IDLE: if pend_e go ALARM; else if pend_d go MELODY; else if pend_t go TICK.
  - TICK: note 3 for TICK_LEN cycles, then IDLE.
  - MELODY: notes 0,1,2,3 for NOTE_LEN cycles each, then IDLE.
  - ALARM: note 0, note 3, repeated ALARM_REPS times, each NOTE_LEN cycles, then IDLE.
- Preemption from any playing state:
  - pend_e while not in ALARM: go ALARM.
  - pend_d while in TICK: go MELODY.
  - The preempted pattern is abandoned and is not resumed.
- Discard rules (the flag clears with no effect):
  - pend_t while in MELODY or ALARM.
  - pend_d while in MELODY or ALARM.
  - pend_e while in ALARM; the alarm does not restart.
  - On a grant of explode, pend_d and pend_t clear. On a grant of defused, pend_t clears.
  - pend_t while in TICK stays set and is granted after the tick ends.
- Tone generation:
  - At each note start, the tone counter and pizo are set to 0.
  - The counter increments each cycle. When it reaches HPn−1, pizo toggles and the counter returns to 0. Period = 2·HPn cycles.
  - Counter width is $clog2 of max(HPn)+1. The duration counter is sized for max(NOTE_LEN, TICK_LEN).
- busy = (state != IDLE). cur_src follows state: IDLE 0, TICK 1, MELODY 2, ALARM 3.
- In IDLE, pizo is held at 0.

## Timing
- A request high before edge k sets its pending flag at edge k. The grant or preempt happens at edge k+1, so state, busy and cur_src change at k+1. Request to sound latency is 2 cycles.
- The first pizo rising edge comes HPn cycles after the note-start edge.
- A pattern occupies exactly its length:
  - TICK_LEN cycles for a tick.
  - 4·NOTE_LEN cycles for the melody.
  - 2·ALARM_REPS·NOTE_LEN cycles for the alarm.
- Each pattern ends by entering IDLE for at least one cycle (pizo=0, busy=0). A queued request starts on the following edge.
- The note boundary is exact. Any partial half-period is truncated and pizo is forced to 0 at the next note start.
- Async rst mid-pattern: all outputs go to their reset values immediately. Requests asserted during reset are lost.
- Requests held continuously high re-set their pending flag every cycle. A held req_tick therefore retriggers back-to-back ticks with one IDLE cycle between them.

## Test plan
Test parameters: HP0=4, HP1=5, HP2=6, HP3=7, NOTE_LEN=40, TICK_LEN=20, ALARM_REPS=2.

- Tick: 1-cycle req_tick at edge 10 → cur_src=1 from edge 11 to 30. pizo toggles every 7 cycles (first rise at edge 18). IDLE at edge 31.
- Melody: req_defused pulse → 160-cycle pattern. pizo half-periods are 4,5,6,7 in 40-cycle segments. busy drops after 160 cycles.
- Preemption: req_tick, then req_explode 5 cycles into the tick → cur_src goes 1→3 at the edge after the explode pend. Alarm lasts 160 cycles alternating HP 4/7. The tick does not resume.
- Discard and queue:
  - req_tick during the melody → dropped; IDLE after the melody.
  - A second req_tick during a tick → a second tick starts after exactly one IDLE cycle.
- Simultaneous: all three requests on the same edge → ALARM only. pend_d and pend_t are cleared, and there is no melody or tick afterward.
- Reset: rst asserted mid-melody → pizo=0, busy=0, cur_src=0 asynchronously. After release, no sound until a new request.
